// File: rtl/nabp_swap_control.sv
// Responder side of the next-iteration / swap handshake between the
// iteration issuer and the two swappable processing units (unit 0, unit 1).
// Hands out one projection-angle iteration at a time with its shifter and
// mapper accumulator seeds, and keeps the shared fill path owned by a
// single unit from its next-iteration ack until its swap ack.
module nabp_swap_control #(
  parameter int NUM_ITR      = 180,
  parameter int SH_W         = 12,
  parameter int MP_INIT_W    = 16,
  parameter int MP_BASE_W    = 16,
  parameter int SH_BASE0     = 0,
  parameter int SH_STEP      = 1,
  parameter int MP_INIT0     = 0,
  parameter int MP_INIT_STEP = 1,
  parameter int MP_BASE0     = 0,
  parameter int MP_BASE_STEP = 1,
  parameter int IDX_W        = (NUM_ITR > 0) ? $clog2(NUM_ITR + 1) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 kick,
  output logic                 done,
  input  logic                 sw_next_itr_0,
  input  logic                 sw_next_itr_1,
  input  logic                 sw_swap_0,
  input  logic                 sw_swap_1,
  output logic                 sw_next_itr_ack_0,
  output logic                 sw_next_itr_ack_1,
  output logic                 sw_swap_ack_0,
  output logic                 sw_swap_ack_1,
  output logic [SH_W-1:0]      sw_sh_accu_base,
  output logic [MP_INIT_W-1:0] sw_mp_accu_init,
  output logic [MP_BASE_W-1:0] sw_mp_accu_base,
  output logic [IDX_W-1:0]     sw_itr_idx
);

  // state   | meaning
  // IDLE_S  | waiting for kick; done holds the result of the last run
  // ISSUE_S | fill path free; grant the next iteration or finish the run
  // FILL_S  | owner holds the fill path; next-itr ack, then wait for its swap

  typedef enum logic [1:0] {
    IDLE_S  = 2'd0,
    ISSUE_S = 2'd1,
    FILL_S  = 2'd2
  } state_t;

  localparam logic [SH_W-1:0]      SH_BASE_C   = SH_W'(SH_BASE0);
  localparam logic [SH_W-1:0]      SH_STEP_C   = SH_W'(SH_STEP);
  localparam logic [MP_INIT_W-1:0] MI_BASE_C   = MP_INIT_W'(MP_INIT0);
  localparam logic [MP_INIT_W-1:0] MI_STEP_C   = MP_INIT_W'(MP_INIT_STEP);
  localparam logic [MP_BASE_W-1:0] MB_BASE_C   = MP_BASE_W'(MP_BASE0);
  localparam logic [MP_BASE_W-1:0] MB_STEP_C   = MP_BASE_W'(MP_BASE_STEP);
  localparam logic [IDX_W-1:0]     IDX_LAST_C  = IDX_W'(NUM_ITR);
  localparam logic [IDX_W-1:0]     IDX_ONE_C   = IDX_W'(1);

  state_t state;
  logic   owner;
  logic   prio_ptr;

  logic   req_any;
  logic   grant_unit;
  logic   owner_swap;
  logic   itr_ack_pending;
  logic   swap_ack_pending;
  logic   idx_done;

  // With both units requesting the pointer decides; otherwise the lone
  // requester wins (unit 1 exactly when only unit 1 asks).
  assign req_any          = sw_next_itr_0 | sw_next_itr_1;
  assign grant_unit       = (sw_next_itr_0 && sw_next_itr_1) ? prio_ptr : sw_next_itr_1;
  assign owner_swap       = owner ? sw_swap_1 : sw_swap_0;
  assign itr_ack_pending  = sw_next_itr_ack_0 | sw_next_itr_ack_1;
  assign swap_ack_pending = sw_swap_ack_0 | sw_swap_ack_1;
  assign idx_done         = (sw_itr_idx == IDX_LAST_C);

  // Handshake FSM: all outputs are registered; ack pulses default low every
  // cycle, so a held request level can never stretch an ack.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state             <= IDLE_S;
      owner             <= 1'b0;
      prio_ptr          <= 1'b0;
      done              <= 1'b0;
      sw_next_itr_ack_0 <= 1'b0;
      sw_next_itr_ack_1 <= 1'b0;
      sw_swap_ack_0     <= 1'b0;
      sw_swap_ack_1     <= 1'b0;
      sw_itr_idx        <= '0;
      sw_sh_accu_base   <= SH_BASE_C;
      sw_mp_accu_init   <= MI_BASE_C;
      sw_mp_accu_base   <= MB_BASE_C;
    end else begin
      sw_next_itr_ack_0 <= 1'b0;
      sw_next_itr_ack_1 <= 1'b0;
      sw_swap_ack_0     <= 1'b0;
      sw_swap_ack_1     <= 1'b0;

      case (state)
        IDLE_S: begin
          if (kick) begin
            state           <= ISSUE_S;
            done            <= 1'b0;
            sw_itr_idx      <= '0;
            sw_sh_accu_base <= SH_BASE_C;
            sw_mp_accu_init <= MI_BASE_C;
            sw_mp_accu_base <= MB_BASE_C;
          end
        end

        ISSUE_S: begin
          if (idx_done) begin
            state <= IDLE_S;
            done  <= 1'b1;
          end else if (req_any) begin
            state    <= FILL_S;
            owner    <= grant_unit;
            prio_ptr <= ~grant_unit;
            if (grant_unit) begin
              sw_next_itr_ack_1 <= 1'b1;
            end else begin
              sw_next_itr_ack_0 <= 1'b1;
            end
          end
        end

        FILL_S: begin
          // Seeds and index stay on iteration idx for the whole ack cycle so
          // the owner latches them on the edge that ends it; step afterwards.
          if (itr_ack_pending) begin
            sw_itr_idx      <= sw_itr_idx + IDX_ONE_C;
            sw_sh_accu_base <= sw_sh_accu_base + SH_STEP_C;
            sw_mp_accu_init <= sw_mp_accu_init + MI_STEP_C;
            sw_mp_accu_base <= sw_mp_accu_base + MB_STEP_C;
          end

          if (swap_ack_pending) begin
            state <= ISSUE_S;
          end else if (owner_swap) begin
            if (owner) begin
              sw_swap_ack_1 <= 1'b1;
            end else begin
              sw_swap_ack_0 <= 1'b1;
            end
          end
        end

        default: begin
          state <= IDLE_S;
        end
      endcase
    end
  end

endmodule
